// File: rtl/am_pkg.sv
// Shared definitions for the adding-machine controller.
// Holds the op-code values decoded from the datapath IR and the controller
// state encoding used by am_controller.
package am_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LDA = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_IDLE   = 4'd1,
        ST_FETCH  = 4'd2,
        ST_DECODE = 4'd3,
        ST_ADD    = 4'd4,
        ST_LDA    = 4'd5,
        ST_STA    = 4'd6,
        ST_JMP    = 4'd7,
        ST_END    = 4'd8
    } state_t;

endpackage

// File: rtl/am_wait_timer.sv
// Memory wait-timeout counter.
// Counts cycles spent in a memory-access state without mem_ready and raises
// a one-cycle timeout in the cycle the count would reach MAX_WAIT.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   active      - controller is in a state that requests memory
//   mem_ready   - memory completes the access this cycle
//   timeout     - combinational pulse: give up on the access at this edge
module am_wait_timer #(
    parameter int TMO_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    // Count value in the wait cycle that would bring the count to MAX_WAIT.
    localparam logic [TMO_W-1:0] LAST = TMO_W'(MAX_WAIT - 1);

    logic [TMO_W-1:0] cnt;
    logic             waiting;

    assign waiting = active & ~mem_ready;
    // A completing access never times out: mem_ready clears waiting.
    assign timeout = (MAX_WAIT != 0) && waiting && (cnt == LAST);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (waiting && !timeout) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/am_controller.sv
// Control unit for the adding-machine CPU.
// Sequences FETCH / DECODE / execute / END against a ready-handshake memory
// and drives every datapath control strobe.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   run              - keep executing; sampled only in IDLE and END
//   op_code          - IR op-code (ADD, LDA, STA, JMP)
//   mem_ready        - memory completes the current access
//   mem_rd, mem_wr   - memory requests
//   ir_on_adr, pc_on_adr - address-bus source select
//   ld_ir, ld_ac, ld_pc, inc_pc, clr_pc - datapath register strobes
//   pass_add         - 1: AC loads data bus / ALU passes AC, 0: ALU add
//   busy             - high outside IDLE
//   bus_err          - sticky memory-timeout flag
module am_controller
    import am_pkg::*;
#(
    parameter int TMO_W    = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [1:0] op_code,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_on_adr,
    output logic       pc_on_adr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       clr_pc,
    output logic       pass_add,
    output logic       busy,
    output logic       bus_err
);

    state_t state, next_state;
    logic   in_access;
    logic   timeout;

    // Derived from the state register alone so the timer input does not
    // depend on the output decode below.
    assign in_access = (state == ST_FETCH) || (state == ST_ADD) ||
                       (state == ST_LDA)   || (state == ST_STA);

    am_wait_timer #(
        .TMO_W    (TMO_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (in_access),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RST;
            bus_err <= 1'b0;
        end else begin
            state <= next_state;
            if (timeout) begin
                bus_err <= 1'b1;
            end
        end
    end

    // NOTE: every output and next_state gets a default before the case so no
    // path through this block can infer a latch.
    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_on_adr  = 1'b0;
        pc_on_adr  = 1'b0;
        ld_ir      = 1'b0;
        ld_ac      = 1'b0;
        ld_pc      = 1'b0;
        inc_pc     = 1'b0;
        clr_pc     = 1'b0;
        pass_add   = 1'b0;
        busy       = 1'b0;

        // While rst_n is low every strobe is forced to 0, so requests drop
        // the instant reset asserts rather than at the next edge.
        if (rst_n) begin
            unique case (state)
                ST_RST: begin
                    clr_pc     = 1'b1;
                    busy       = 1'b1;
                    next_state = ST_IDLE;
                end
                ST_IDLE: begin
                    // A sticky bus error locks the machine here until reset.
                    if (run && !bus_err) begin
                        next_state = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    busy      = 1'b1;
                    pc_on_adr = 1'b1;
                    mem_rd    = 1'b1;
                    if (mem_ready) begin
                        ld_ir      = 1'b1;
                        inc_pc     = 1'b1;
                        next_state = ST_DECODE;
                    end else if (timeout) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    busy = 1'b1;
                    unique case (op_code)
                        OP_ADD:  next_state = ST_ADD;
                        OP_LDA:  next_state = ST_LDA;
                        OP_STA:  next_state = ST_STA;
                        default: next_state = ST_JMP;
                    endcase
                end
                ST_ADD, ST_LDA: begin
                    busy      = 1'b1;
                    ir_on_adr = 1'b1;
                    mem_rd    = 1'b1;
                    pass_add  = (state == ST_LDA);
                    if (mem_ready) begin
                        ld_ac      = 1'b1;
                        next_state = ST_END;
                    end else if (timeout) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_STA: begin
                    busy      = 1'b1;
                    ir_on_adr = 1'b1;
                    mem_wr    = 1'b1;
                    pass_add  = 1'b1;
                    if (mem_ready) begin
                        next_state = ST_END;
                    end else if (timeout) begin
                        next_state = ST_IDLE;
                    end
                end
                ST_JMP: begin
                    busy       = 1'b1;
                    ld_pc      = 1'b1;
                    next_state = ST_END;
                end
                ST_END: begin
                    busy       = 1'b1;
                    next_state = run ? ST_FETCH : ST_IDLE;
                end
                default: begin
                    next_state = ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_am_controller.sv
// Self-checking bench for am_controller: a cycle-by-cycle vector table
// followed by hand-written asynchronous-reset sequences.
module tb_am_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [1:0] op_code;
    logic       mem_ready;
    logic       mem_rd, mem_wr, ir_on_adr, pc_on_adr;
    logic       ld_ir, ld_ac, ld_pc, inc_pc, clr_pc, pass_add, busy, bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    am_controller #(
        .TMO_W    (4),
        .MAX_WAIT (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .op_code   (op_code),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_on_adr (ir_on_adr),
        .pc_on_adr (pc_on_adr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .clr_pc    (clr_pc),
        .pass_add  (pass_add),
        .busy      (busy),
        .bus_err   (bus_err)
    );

    // Output vector, MSB first:
    // mem_rd mem_wr ir_on_adr pc_on_adr ld_ir ld_ac ld_pc inc_pc clr_pc pass_add busy bus_err
    logic [11:0] outs;
    assign outs = {mem_rd, mem_wr, ir_on_adr, pc_on_adr, ld_ir, ld_ac,
                   ld_pc, inc_pc, clr_pc, pass_add, busy, bus_err};

    localparam logic [11:0] B_RD   = 12'h800;
    localparam logic [11:0] B_WR   = 12'h400;
    localparam logic [11:0] B_IRA  = 12'h200;
    localparam logic [11:0] B_PCA  = 12'h100;
    localparam logic [11:0] B_LDIR = 12'h080;
    localparam logic [11:0] B_LDAC = 12'h040;
    localparam logic [11:0] B_LDPC = 12'h020;
    localparam logic [11:0] B_INC  = 12'h010;
    localparam logic [11:0] B_CLR  = 12'h008;
    localparam logic [11:0] B_PASS = 12'h004;
    localparam logic [11:0] B_BUSY = 12'h002;
    localparam logic [11:0] B_ERR  = 12'h001;

    localparam logic [11:0] O_IDLE = 12'h000;
    localparam logic [11:0] O_RST  = B_CLR | B_BUSY;
    localparam logic [11:0] O_FW   = B_RD | B_PCA | B_BUSY;
    localparam logic [11:0] O_FR   = O_FW | B_LDIR | B_INC;
    localparam logic [11:0] O_DEC  = B_BUSY;
    localparam logic [11:0] O_AW   = B_RD | B_IRA | B_BUSY;
    localparam logic [11:0] O_AR   = O_AW | B_LDAC;
    localparam logic [11:0] O_LW   = O_AW | B_PASS;
    localparam logic [11:0] O_LR   = O_LW | B_LDAC;
    localparam logic [11:0] O_SW   = B_WR | B_IRA | B_PASS | B_BUSY;
    localparam logic [11:0] O_J    = B_LDPC | B_BUSY;
    localparam logic [11:0] O_END  = B_BUSY;

    typedef struct {
        logic        run;
        logic [1:0]  op;
        logic        rdy;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] o, input logic y,
                       input logic [11:0] e);
        vec_t v;
        v.run = r;
        v.op  = o;
        v.rdy = y;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // Fresh reset through first zero-wait ADD.
        add(1, 2'd0, 0, O_RST);            // 0  RST: clr_pc pulse
        add(1, 2'd0, 0, O_IDLE);           // 1  IDLE, run -> FETCH
        add(1, 2'd0, 1, O_FR);             // 2  FETCH zero-wait
        add(1, 2'd0, 0, O_DEC);            // 3  DECODE -> ADD
        add(1, 2'd0, 1, O_AR);             // 4  ADD zero-wait
        add(1, 2'd0, 0, O_END);            // 5  END -> FETCH
        // ADD with 2-wait memory.
        add(1, 2'd0, 1, O_FR);             // 6
        add(1, 2'd0, 0, O_DEC);            // 7
        add(1, 2'd0, 0, O_AW);             // 8
        add(1, 2'd0, 0, O_AW);             // 9
        add(1, 2'd0, 1, O_AR);             // 10
        add(1, 2'd1, 0, O_END);            // 11
        // LDA with 2-wait memory.
        add(1, 2'd1, 1, O_FR);             // 12
        add(1, 2'd1, 0, O_DEC);            // 13
        add(1, 2'd1, 0, O_LW);             // 14
        add(1, 2'd1, 0, O_LW);             // 15
        add(1, 2'd1, 1, O_LR);             // 16
        add(1, 2'd2, 0, O_END);            // 17
        // STA, one wait.
        add(1, 2'd2, 1, O_FR);             // 18
        add(1, 2'd2, 0, O_DEC);            // 19
        add(1, 2'd2, 0, O_SW);             // 20
        add(1, 2'd2, 1, O_SW);             // 21 completes, no strobe
        add(1, 2'd3, 0, O_END);            // 22
        // JMP: mem_ready ignored, FETCH two cycles after ld_pc.
        add(1, 2'd3, 1, O_FR);             // 23
        add(1, 2'd3, 0, O_DEC);            // 24
        add(1, 2'd3, 1, O_J);              // 25
        add(1, 2'd0, 0, O_END);            // 26
        add(1, 2'd0, 1, O_FR);             // 27
        add(1, 2'd0, 0, O_DEC);            // 28
        // run dropped during ADD wait: instruction still completes.
        add(0, 2'd0, 0, O_AW);             // 29
        add(0, 2'd0, 1, O_AR);             // 30
        add(0, 2'd0, 0, O_END);            // 31 -> IDLE
        add(0, 2'd0, 1, O_IDLE);           // 32 mem_ready ignored in IDLE
        add(1, 2'd0, 0, O_IDLE);           // 33 -> FETCH
        add(1, 2'd0, 0, O_FW);             // 34 fetch wait
        add(0, 2'd0, 1, O_FR);             // 35
        add(0, 2'd0, 1, O_DEC);            // 36 mem_ready ignored in DECODE
        // Completion in the limit cycle wins over the timeout.
        add(0, 2'd0, 0, O_AW);             // 37
        add(0, 2'd0, 0, O_AW);             // 38
        add(0, 2'd0, 1, O_AR);             // 39
        add(0, 2'd0, 0, O_END);            // 40 -> IDLE
        // Fetch timeout after 3 wait cycles.
        add(1, 2'd0, 0, O_IDLE);           // 41
        add(1, 2'd0, 0, O_FW);             // 42
        add(1, 2'd0, 0, O_FW);             // 43
        add(1, 2'd0, 0, O_FW);             // 44 times out at this edge
        add(1, 2'd0, 1, O_IDLE | B_ERR);   // 45 run ignored
        add(1, 2'd0, 0, O_IDLE | B_ERR);   // 46

        // Reset held: outputs all zero even with run high.
        rst_n     = 1'b0;
        run       = 1'b1;
        op_code   = 2'd0;
        mem_ready = 1'b0;
        #1;
        check("reset_outputs", outs, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run       = vecs[i].run;
            op_code   = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("row%0d", i), outs, vecs[i].exp);
            check($sformatf("row%0d_rd_wr_excl", i),
                  {11'd0, mem_rd & mem_wr}, 12'h000);
            check($sformatf("row%0d_adr_excl", i),
                  {11'd0, ir_on_adr & pc_on_adr}, 12'h000);
            @(negedge clk);
        end

        // Reset clears the sticky error.
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("reset_clears_err", outs, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        #1;
        check("rerun_rst", outs, O_RST);
        @(negedge clk);
        #1;
        check("rerun_idle", outs, O_IDLE);
        @(negedge clk);
        #1;
        check("rerun_fetch_wait", outs, O_FW);
        // Asynchronous abort mid-fetch, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_abort", outs, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b0;
        #1;
        check("post_abort_rst", outs, O_RST);
        @(negedge clk);
        #1;
        check("post_abort_idle", outs, O_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
